// File: rtl/dtcm_arb_ctrl_pkg.sv
// Shared DTCM geometry defaults and helpers for the multi-port DTCM controller.
// Modules derive their address/data widths from these unless overridden.
package dtcm_arb_ctrl_pkg;

    localparam int DTCM_ADDR_WIDTH = 16;
    localparam int DTCM_RAM_DW     = 32;
    localparam int DTCM_RAM_MW     = DTCM_RAM_DW / 8;
    localparam int DTCM_RAM_AW     = DTCM_ADDR_WIDTH - $clog2(DTCM_RAM_MW);

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dtcm_rsp_fifo.sv
// Per-port response buffer: a small synchronous FIFO holding responses the
// requester could not take in the cycle they came back from the RAM.
module dtcm_rsp_fifo
    import dtcm_arb_ctrl_pkg::*;
#(
    parameter int DW    = DTCM_RAM_DW,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int PW = idx_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage is not reset; occupancy is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Credits bound occupancy, so a push into a full buffer means broken flow control.
    assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/dtcm_arb_ctrl.sv
// Multi-port DTCM controller: round-robin arbitration of NPORT requesters onto a
// single-port SRAM, with credit-limited commands and buffered in-order responses.
module dtcm_arb_ctrl
    import dtcm_arb_ctrl_pkg::*;
#(
    parameter int NPORT     = 2,
    parameter int AW        = DTCM_ADDR_WIDTH,
    parameter int DW        = DTCM_RAM_DW,
    parameter int MW        = DW / 8,
    parameter int RAW       = AW - $clog2(MW),
    parameter int RSP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    cmd_valid,
    output logic [NPORT-1:0]    cmd_ready,
    input  logic [NPORT-1:0]    cmd_read,
    input  logic [NPORT*AW-1:0] cmd_addr,
    input  logic [NPORT*MW-1:0] cmd_wmask,
    input  logic [NPORT*DW-1:0] cmd_wdata,
    output logic [NPORT-1:0]    rsp_valid,
    input  logic [NPORT-1:0]    rsp_ready,
    output logic [NPORT*DW-1:0] rsp_rdata,
    output logic                ram_cs,
    output logic                ram_we,
    output logic [RAW-1:0]      ram_addr,
    output logic [MW-1:0]       ram_wem,
    output logic [DW-1:0]       ram_din,
    input  logic [DW-1:0]       ram_dout
);

    localparam int PW = idx_width(NPORT);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int LW = $clog2(MW);

    logic [PW-1:0]    rr;
    logic [PW-1:0]    winner;
    logic             any_grant;
    logic [NPORT-1:0] eligible;
    logic [NPORT-1:0] grant;

    logic             s1_valid;
    logic             s1_read;
    logic [PW-1:0]    s1_port;
    logic [DW-1:0]    s1_data;

    // First eligible port at or after the priority pointer wins.
    always_comb begin
        int idx;
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int i = 0; i < NPORT; i++) begin
            idx = (int'(rr) + i) % NPORT;
            if (!any_grant && eligible[idx]) begin
                any_grant   = 1'b1;
                winner      = PW'(idx);
                grant[idx]  = 1'b1;
            end
        end
    end

    assign cmd_ready = grant;
    assign ram_cs    = any_grant;
    assign ram_we    = any_grant && !cmd_read[winner];
    assign ram_addr  = cmd_addr[int'(winner)*AW + LW +: RAW];
    assign ram_wem   = cmd_wmask[int'(winner)*MW +: MW];
    assign ram_din   = cmd_wdata[int'(winner)*DW +: DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr       <= '0;
            s1_valid <= 1'b0;
            s1_port  <= '0;
            s1_read  <= 1'b0;
        end else begin
            s1_valid <= any_grant;
            s1_port  <= winner;
            s1_read  <= cmd_read[winner];
            if (any_grant) begin
                rr <= (winner == PW'(NPORT - 1)) ? '0 : winner + PW'(1);
            end
        end
    end

    assign s1_data = s1_read ? ram_dout : '0;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic          s1_hit;
        logic          push;
        logic          pop;
        logic          empty;
        logic          full;
        logic          rsp_fire;
        logic [DW-1:0] head;
        logic [CW-1:0] credit;
        logic          unused_addr_lsb;

        assign unused_addr_lsb = ^cmd_addr[p*AW +: LW];

        // Fresh RAM data bypasses an empty buffer; otherwise it queues behind the head.
        assign s1_hit   = s1_valid && (s1_port == PW'(p));
        assign push     = s1_hit && (!empty || !rsp_ready[p]);
        assign pop      = !empty && rsp_ready[p];
        assign rsp_fire = rsp_valid[p] && rsp_ready[p];

        assign rsp_valid[p]          = !empty || s1_hit;
        assign rsp_rdata[p*DW +: DW] = empty ? s1_data : head;
        assign eligible[p]           = cmd_valid[p] && (credit < CW'(RSP_DEPTH));

        dtcm_rsp_fifo #(
            .DW    (DW),
            .DEPTH (RSP_DEPTH)
        ) u_rsp_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push),
            .pop   (pop),
            .din   (s1_data),
            .dout  (head),
            .empty (empty),
            .full  (full)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                credit <= '0;
            end else if (grant[p] && !rsp_fire) begin
                credit <= credit + CW'(1);
            end else if (!grant[p] && rsp_fire) begin
                credit <= credit - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dtcm_arb_ctrl.sv
// Scoreboard bench for dtcm_arb_ctrl: directed commands per port, expected
// responses queued on acceptance and checked by an independent monitor.
module tb_dtcm_arb_ctrl;

    localparam int NPORT = 2;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int RAW   = 14;
    localparam int DEPTH = 2;

    typedef struct {
        bit          read;
        logic [15:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] exp;
        bit          chk_lat;
    } cmd_t;

    typedef struct {
        logic [31:0] data;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic                clk;
    logic                rst;
    logic [NPORT-1:0]    cmd_valid;
    logic [NPORT-1:0]    cmd_ready;
    logic [NPORT-1:0]    cmd_read;
    logic [NPORT*AW-1:0] cmd_addr;
    logic [NPORT*MW-1:0] cmd_wmask;
    logic [NPORT*DW-1:0] cmd_wdata;
    logic [NPORT-1:0]    rsp_valid;
    logic [NPORT-1:0]    rsp_ready;
    logic [NPORT*DW-1:0] rsp_rdata;
    logic                ram_cs;
    logic                ram_we;
    logic [RAW-1:0]      ram_addr;
    logic [MW-1:0]       ram_wem;
    logic [DW-1:0]       ram_din;
    logic [DW-1:0]       ram_dout;

    logic [31:0] mem [0:(1<<RAW)-1];

    cmd_t cmd_q [NPORT][$];
    exp_t exp_q [NPORT][$];
    int   glog_port [$];
    int   glog_cyc [$];
    int   acc_cnt [NPORT];
    int   cyc;
    int   errors;
    int   checks;

    dtcm_arb_ctrl #(
        .NPORT     (NPORT),
        .AW        (AW),
        .DW        (DW),
        .MW        (MW),
        .RAW       (RAW),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_read  (cmd_read),
        .cmd_addr  (cmd_addr),
        .cmd_wmask (cmd_wmask),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wem   (ram_wem),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Behavioural single-port SRAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < MW; b++) begin
                    if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
                end
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int p, input bit rd, input logic [15:0] addr,
                                 input logic [3:0] wm, input logic [31:0] wd,
                                 input logic [31:0] exp, input bit lat);
        cmd_t c;
        c.read = rd; c.addr = addr; c.wmask = wm; c.wdata = wd; c.exp = exp; c.chk_lat = lat;
        cmd_q[p].push_back(c);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((cmd_q[0].size() + cmd_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL idle_timeout: got %0d cycles pending, required drain within %0d", n, budget);
        end
        @(negedge clk);
    endtask

    // Driver: presents each port's queue head, drops valid immediately on reset.
    initial begin
        cmd_valid = '0; cmd_read = '0; cmd_addr = '0; cmd_wmask = '0; cmd_wdata = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (!rst) #1;
            for (int p = 0; p < NPORT; p++) begin
                if (!rst && cmd_q[p].size() > 0) begin
                    cmd_valid[p]           = 1'b1;
                    cmd_read[p]            = cmd_q[p][0].read;
                    cmd_addr[p*AW +: AW]   = cmd_q[p][0].addr;
                    cmd_wmask[p*MW +: MW]  = cmd_q[p][0].wmask;
                    cmd_wdata[p*DW +: DW]  = cmd_q[p][0].wdata;
                end else begin
                    cmd_valid[p] = 1'b0;
                end
            end
        end
    end

    // Monitor: checks response handshakes, then records commands accepted at the next edge.
    initial begin
        exp_t e;
        cmd_t c;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int p = 0; p < NPORT; p++) begin
                    if (rsp_valid[p] && rsp_ready[p]) begin
                        if (exp_q[p].size() == 0) begin
                            checks = checks + 1;
                            errors = errors + 1;
                            $display("[TB] FAIL unexpected_rsp_p%0d: got rdata %h, required no response",
                                     p, rsp_rdata[p*DW +: DW]);
                        end else begin
                            e = exp_q[p].pop_front();
                            checkOutput($sformatf("rsp_rdata_p%0d", p), rsp_rdata[p*DW +: DW], e.data);
                            if (e.chk_lat)
                                checkOutput($sformatf("rsp_latency_p%0d", p), 32'(cyc - e.acc_cyc), 32'd1);
                        end
                    end
                end
                for (int p = 0; p < NPORT; p++) begin
                    if (cmd_valid[p] && cmd_ready[p] && cmd_q[p].size() > 0) begin
                        c = cmd_q[p].pop_front();
                        e.data = c.exp; e.acc_cyc = cyc; e.chk_lat = c.chk_lat;
                        exp_q[p].push_back(e);
                        acc_cnt[p] = acc_cnt[p] + 1;
                        glog_port.push_back(p);
                        glog_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first;
        errors = 0;
        checks = 0;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        rst = 1'b1;
        rsp_ready = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_ram_cs", 32'(ram_cs), 32'd0);
        checkOutput("reset_ram_we", 32'(ram_we), 32'd0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        $display("[TB] single write/read, read-after-write");
        applyStimulus(0, 1'b0, 16'h0010, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1);
        applyStimulus(0, 1'b1, 16'h0012, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
        waitIdle(50);

        $display("[TB] byte mask");
        applyStimulus(0, 1'b0, 16'h0020, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1);
        applyStimulus(0, 1'b0, 16'h0020, 4'h5, 32'h11223344, 32'h0, 1'b1);
        applyStimulus(0, 1'b1, 16'h0020, 4'h0, 32'h0, 32'hFF22FF44, 1'b1);
        waitIdle(50);

        $display("[TB] cross-port write then read");
        applyStimulus(1, 1'b0, 16'h0030, 4'hF, 32'hCAFEF00D, 32'h0, 1'b1);
        waitIdle(50);
        applyStimulus(0, 1'b1, 16'h0030, 4'h0, 32'h0, 32'hCAFEF00D, 1'b1);
        waitIdle(50);

        $display("[TB] contention");
        glog_port.delete(); glog_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b1, 16'h0010, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
            applyStimulus(1, 1'b1, 16'h0020, 4'h0, 32'h0, 32'hFF22FF44, 1'b1);
        end
        waitIdle(100);
        checkOutput("contention_grant_count", 32'(glog_port.size()), 32'd8);
        for (int i = 1; i < glog_port.size(); i++) begin
            checkOutput($sformatf("contention_alt_%0d", i), 32'(glog_port[i]), 32'(1 - glog_port[i-1]));
            checkOutput($sformatf("contention_gap_%0d", i), 32'(glog_cyc[i] - glog_cyc[i-1]), 32'd1);
        end

        $display("[TB] back-pressure on port 1");
        @(posedge clk); #2;
        rsp_ready[1] = 1'b0;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        applyStimulus(1, 1'b0, 16'h0050, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0);
        applyStimulus(1, 1'b1, 16'h0050, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
        applyStimulus(1, 1'b1, 16'h0010, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        applyStimulus(1, 1'b1, 16'h0020, 4'h0, 32'h0, 32'hFF22FF44, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 1'b1, 16'h0010, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
        repeat (12) @(negedge clk);
        checkOutput("bp_p1_accepts", 32'(acc_cnt[1]), 32'd2);
        checkOutput("bp_p0_accepts", 32'(acc_cnt[0]), 32'd6);
        checkOutput("bp_p1_valid", 32'(cmd_valid[1]), 32'd1);
        checkOutput("bp_p1_ready", 32'(cmd_ready[1]), 32'd0);
        checkOutput("bp_p1_rsp_valid", 32'(rsp_valid[1]), 32'd1);
        checkOutput("bp_p1_head", rsp_rdata[DW +: DW], 32'h0);
        @(posedge clk); #2;
        rsp_ready[1] = 1'b1;
        waitIdle(100);
        checkOutput("bp_p1_accepts_after", 32'(acc_cnt[1]), 32'd4);

        $display("[TB] reset mid-burst");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b1, 16'h0050, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
            applyStimulus(1, 1'b1, 16'h0010, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        end
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        for (int p = 0; p < NPORT; p++) begin
            cmd_q[p].delete();
            exp_q[p].delete();
        end
        @(negedge clk);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_ram_cs", 32'(ram_cs), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("postrst_no_stale", 32'(rsp_valid), 32'd0);
        glog_port.delete(); glog_cyc.delete();
        applyStimulus(0, 1'b1, 16'h0050, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b1);
        applyStimulus(1, 1'b1, 16'h0020, 4'h0, 32'h0, 32'hFF22FF44, 1'b1);
        waitIdle(50);
        first = (glog_port.size() > 0) ? glog_port[0] : -1;
        checkOutput("postrst_first_grant", 32'(first), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
